// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_pkg
//  Description : Shared constants for the RTC access sequencer: FSM state
//                encoding, field indices, RTC register addresses and the
//                legal BCD range of every time/date field.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_GAP     = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_WAIT = 3'd4
  } state_t;

  // Field indices, shared by edit_sel and the shadow bank
  localparam int unsigned NUM_FIELDS = 6;
  localparam logic [2:0]  FLD_SEG    = 3'd0;
  localparam logic [2:0]  FLD_MIN    = 3'd1;
  localparam logic [2:0]  FLD_HORA   = 3'd2;
  localparam logic [2:0]  FLD_DIA    = 3'd3;
  localparam logic [2:0]  FLD_MES    = 3'd4;
  localparam logic [2:0]  FLD_ANIO   = 3'd5;

  // RTC register map: fields are consecutive starting at 0x21
  localparam logic [7:0]  ADDR_BASE  = 8'h21;
  localparam logic [7:0]  ADDR_SEG   = 8'h21;
  localparam logic [7:0]  ADDR_MIN   = 8'h22;
  localparam logic [7:0]  ADDR_HORA  = 8'h23;
  localparam logic [7:0]  ADDR_DIA   = 8'h24;
  localparam logic [7:0]  ADDR_MES   = 8'h25;
  localparam logic [7:0]  ADDR_ANIO  = 8'h26;

  // Legal BCD ranges
  localparam logic [7:0]  MIN_SEG  = 8'h00, MAX_SEG  = 8'h59;
  localparam logic [7:0]  MIN_MIN  = 8'h00, MAX_MIN  = 8'h59;
  localparam logic [7:0]  MIN_HORA = 8'h00, MAX_HORA = 8'h23;
  localparam logic [7:0]  MIN_DIA  = 8'h01, MAX_DIA  = 8'h31;
  localparam logic [7:0]  MIN_MES  = 8'h01, MAX_MES  = 8'h12;
  localparam logic [7:0]  MIN_ANIO = 8'h00, MAX_ANIO = 8'h99;

  function automatic logic [7:0] field_addr(input logic [2:0] fld);
    return ADDR_BASE + {5'd0, fld};
  endfunction

  function automatic logic [7:0] field_min(input logic [2:0] fld);
    logic [7:0] r;
    case (fld)
      FLD_SEG:  r = MIN_SEG;
      FLD_MIN:  r = MIN_MIN;
      FLD_HORA: r = MIN_HORA;
      FLD_DIA:  r = MIN_DIA;
      FLD_MES:  r = MIN_MES;
      FLD_ANIO: r = MIN_ANIO;
      default:  r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] field_max(input logic [2:0] fld);
    logic [7:0] r;
    case (fld)
      FLD_SEG:  r = MAX_SEG;
      FLD_MIN:  r = MAX_MIN;
      FLD_HORA: r = MAX_HORA;
      FLD_DIA:  r = MAX_DIA;
      FLD_MES:  r = MAX_MES;
      FLD_ANIO: r = MAX_ANIO;
      default:  r = 8'h00;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_ajuste.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_ajuste
//  Description : One-step BCD increment/decrement within [min, max] with
//                wrap-around. Illegal inputs are treated as min first.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_ajuste (
  input  logic [7:0] value,
  input  logic [7:0] min,
  input  logic [7:0] max,
  input  logic       up,
  output logic [7:0] result
);

  logic [7:0] base;
  logic [3:0] hi;
  logic [3:0] lo;

  // Sanitize the input, then step by one BCD unit with carry/borrow and wrap
  always_comb begin
    base = value;
    if ((value[7:4] > 4'd9) || (value[3:0] > 4'd9) || (value < min) || (value > max)) begin
      base = min;
    end
    hi     = base[7:4];
    lo     = base[3:0];
    result = base;
    if (up) begin
      if (base == max)     result = min;
      else if (lo == 4'd9) result = {hi + 4'd1, 4'd0};
      else                 result = {hi, lo + 4'd1};
    end else begin
      if (base == min)     result = max;
      else if (lo == 4'd0) result = {hi - 4'd1, 4'd9};
      else                 result = {hi, lo - 4'd1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/rtc_secuenciador.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_secuenciador
//  Description : Chooses the next RTC register transaction. Polls the six
//                time/date registers into a BCD shadow bank and inserts
//                BCD-adjusted write transactions for user inc/dec edits.
//                Transactions are purely time-based (T_TRANS cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_secuenciador
  import rtc_pkg::*;
#(
  parameter int unsigned T_TRANS  = 74,
  parameter int unsigned T_CAPT   = 70,
  parameter int unsigned POLL_GAP = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_vga,
  input  logic [2:0] edit_sel,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] address,
  output logic [7:0] DATA_WRITE,
  output logic       IndicadorMaquina,
  output logic       busy,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio
);

  localparam int unsigned TW = (T_TRANS > 1) ? $clog2(T_TRANS) : 1;
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [TW-1:0] TRANS_LAST = TW'(T_TRANS - 1);
  localparam logic [TW-1:0] CAPT_IDX   = TW'(T_CAPT);
  localparam logic [GW-1:0] GAP_LAST   = GW'(POLL_GAP - 1);

  state_t                         state_q, state_d;
  logic [2:0]                     idx_q, idx_d;
  logic [TW-1:0]                  trans_q, trans_d;
  logic [GW-1:0]                  gap_q, gap_d;
  logic                           pend_q, pend_d;
  logic [2:0]                     pend_field_q, pend_field_d;
  logic                           pend_up_q, pend_up_d;
  logic [2:0]                     wr_field_q, wr_field_d;
  logic [7:0]                     address_q, address_d;
  logic [7:0]                     data_write_q, data_write_d;
  logic                           ind_q, ind_d;
  logic                           busy_q, busy_d;
  logic [NUM_FIELDS-1:0][7:0]     shadow_q, shadow_d;

  logic                           req_ok;
  logic [7:0]                     sel_val;
  logic [7:0]                     adj_val;

  assign req_ok = (inc ^ dec) && (edit_sel <= FLD_ANIO);

  // Shadow value of the pending field, the starting point of the BCD step
  always_comb begin
    sel_val = 8'h00;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (pend_field_q == 3'(i)) sel_val = shadow_q[i];
    end
  end

  bcd_ajuste u_bcd_ajuste (
    .value  (sel_val),
    .min    (field_min(pend_field_q)),
    .max    (field_max(pend_field_q)),
    .up     (pend_up_q),
    .result (adj_val)
  );

  // Next-state, edit capture, shadow update and registered bus outputs
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    trans_d      = trans_q;
    gap_d        = gap_q;
    pend_d       = pend_q;
    pend_field_d = pend_field_q;
    pend_up_d    = pend_up_q;
    wr_field_d   = wr_field_q;
    address_d    = address_q;
    data_write_d = data_write_q;
    ind_d        = ind_q;
    shadow_d     = shadow_q;

    // First request wins; the WR cycle frees the slot for a fresh request
    if (req_ok && (!pend_q || (state_q == ST_WR))) begin
      pend_d       = 1'b1;
      pend_field_d = edit_sel;
      pend_up_d    = inc;
    end else if (state_q == ST_WR) begin
      pend_d       = 1'b0;
    end

    case (state_q)
      ST_GAP: begin
        if (gap_q == '0) begin
          idx_d   = 3'd0;
          state_d = pend_q ? ST_WR : ST_RD;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      // RD/WR are cycle 0 of a transaction; the wait states cover 1..T_TRANS-1
      ST_RD: begin
        trans_d = TW'(1);
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (trans_q == CAPT_IDX) begin
          for (int i = 0; i < NUM_FIELDS; i++) begin
            if (idx_q == 3'(i)) shadow_d[i] = data_vga;
          end
        end
        if (trans_q == TRANS_LAST) begin
          if (pend_q) begin
            // A write after the last field starts a fresh sweep afterwards
            idx_d   = (idx_q == FLD_ANIO) ? 3'd0 : idx_q + 3'd1;
            state_d = ST_WR;
          end else if (idx_q == FLD_ANIO) begin
            gap_d   = GAP_LAST;
            state_d = ST_GAP;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_RD;
          end
        end else begin
          trans_d = trans_q + 1'b1;
        end
      end
      ST_WR: begin
        trans_d = TW'(1);
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (trans_q == TRANS_LAST) begin
          for (int i = 0; i < NUM_FIELDS; i++) begin
            if (wr_field_q == 3'(i)) shadow_d[i] = data_write_q;
          end
          state_d = ST_RD;
        end else begin
          trans_d = trans_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_GAP;
        gap_d   = '0;
      end
    endcase

    // Bus outputs are loaded on entry so they are valid for all of cycle 0
    if ((state_d == ST_RD) && (state_q != ST_RD)) begin
      address_d = ADDR_BASE + {5'd0, idx_d};
      ind_d     = 1'b1;
    end
    if ((state_d == ST_WR) && (state_q != ST_WR)) begin
      address_d    = field_addr(pend_field_q);
      data_write_d = adj_val;
      ind_d        = 1'b0;
      wr_field_d   = pend_field_q;
    end
    busy_d = (state_d != ST_GAP);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_GAP;
      idx_q        <= 3'd0;
      trans_q      <= '0;
      gap_q        <= '0;
      pend_q       <= 1'b0;
      pend_field_q <= 3'd0;
      pend_up_q    <= 1'b0;
      wr_field_q   <= 3'd0;
      address_q    <= ADDR_SEG;
      data_write_q <= 8'h00;
      ind_q        <= 1'b1;
      busy_q       <= 1'b0;
      shadow_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      trans_q      <= trans_d;
      gap_q        <= gap_d;
      pend_q       <= pend_d;
      pend_field_q <= pend_field_d;
      pend_up_q    <= pend_up_d;
      wr_field_q   <= wr_field_d;
      address_q    <= address_d;
      data_write_q <= data_write_d;
      ind_q        <= ind_d;
      busy_q       <= busy_d;
      shadow_q     <= shadow_d;
    end
  end

  assign address          = address_q;
  assign DATA_WRITE       = data_write_q;
  assign IndicadorMaquina = ind_q;
  assign busy             = busy_q;
  assign seg              = shadow_q[FLD_SEG];
  assign min              = shadow_q[FLD_MIN];
  assign hora             = shadow_q[FLD_HORA];
  assign dia              = shadow_q[FLD_DIA];
  assign mes              = shadow_q[FLD_MES];
  assign anio             = shadow_q[FLD_ANIO];

endmodule
`default_nettype wire

// File: tb/tb_rtc_secuenciador.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_secuenciador
//  Description : Self-checking bench for rtc_secuenciador with a protocol
//                stage model and a transaction scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_secuenciador;

  localparam int T_TRANS  = 74;
  localparam int T_CAPT   = 70;
  localparam int POLL_GAP = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_vga;
  logic [2:0] edit_sel;
  logic       inc, dec;
  logic [7:0] address, DATA_WRITE;
  logic       IndicadorMaquina, busy;
  logic [7:0] seg, min, hora, dia, mes, anio;

  rtc_secuenciador #(
    .T_TRANS  (T_TRANS),
    .T_CAPT   (T_CAPT),
    .POLL_GAP (POLL_GAP)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data_vga         (data_vga),
    .edit_sel         (edit_sel),
    .inc              (inc),
    .dec              (dec),
    .address          (address),
    .DATA_WRITE       (DATA_WRITE),
    .IndicadorMaquina (IndicadorMaquina),
    .busy             (busy),
    .seg              (seg),
    .min              (min),
    .hora             (hora),
    .dia              (dia),
    .mes              (mes),
    .anio             (anio)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rd;
  } txn_t;

  txn_t       exp_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] regs [6];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_reads();
    for (int i = 0; i < 6; i++) exp_q.push_back('{addr: 8'h21 + 8'(i), data: 8'h00, rd: 1'b1});
  endtask

  task automatic push_write(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{addr: a, data: d, rd: 1'b0});
  endtask

  task automatic pulse(input logic i_inc, input logic i_dec, input logic [2:0] sel);
    @(negedge clk);
    inc = i_inc; dec = i_dec; edit_sel = sel;
    @(negedge clk);
    inc = 1'b0; dec = 1'b0; edit_sel = 3'd0;
  endtask

  // Waits for busy to be high, then for the end of that busy stretch
  task automatic wait_sweep_end(input string name);
    int  n;
    n = 0;
    while (!busy && n < 1200) begin @(negedge clk); n++; end
    if (!busy) begin n_cmp++; n_fail++; $display("FAIL %s_rise: busy=%b required 1", name, busy); return; end
    n = 0;
    while (busy && n < 1200) begin @(negedge clk); n++; end
    if (busy) begin n_cmp++; n_fail++; $display("FAIL %s_fall: busy=%b required 0", name, busy); end
  endtask

  task automatic wait_txn(input string name, input logic [7:0] a, input logic rd);
    int n;
    n = 0;
    while (!(busy && address == a && IndicadorMaquina == rd) && n < 1200) begin @(negedge clk); n++; end
    if (!(busy && address == a && IndicadorMaquina == rd)) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: address=%h ind=%b required %h/%b", name, address, IndicadorMaquina, a, rd);
    end
  endtask

  // Protocol stage model and scoreboard monitor
  initial begin : monitor
    logic [7:0] pa;
    logic       pb, pi, in_txn, start;
    int         tidx, ix;
    txn_t       e;
    pa = 8'h00; pb = 1'b0; pi = 1'b1; in_txn = 1'b0; tidx = 0;
    data_vga = 8'hEE;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        in_txn = 1'b0; pb = 1'b0; data_vga = 8'hEE;
      end else begin
        start = busy && (!pb || address !== pa || IndicadorMaquina !== pi);
        if (in_txn && (start || !busy)) begin
          n_cmp++;
          if (tidx + 1 != T_TRANS) begin
            n_fail++;
            $display("FAIL txn_len: got %0d cycles required %0d", tidx + 1, T_TRANS);
          end
        end
        if (start) begin
          tidx = 0; in_txn = 1'b1;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL txn_unexpected: addr=%h ind=%b data=%h required none", address, IndicadorMaquina, DATA_WRITE);
          end else begin
            e = exp_q.pop_front();
            if (address !== e.addr || IndicadorMaquina !== e.rd || (!e.rd && DATA_WRITE !== e.data)) begin
              n_fail++;
              $display("FAIL txn: addr=%h ind=%b data=%h required addr=%h ind=%b data=%h",
                       address, IndicadorMaquina, DATA_WRITE, e.addr, e.rd, e.data);
            end
          end
        end else if (busy) begin
          tidx++;
        end else begin
          in_txn = 1'b0;
        end
        pb = busy; pa = address; pi = IndicadorMaquina;
        ix = int'(address) - 'h21;
        data_vga = 8'hEE;
        if (in_txn && tidx == T_CAPT && ix >= 0 && ix < 6) begin
          if (IndicadorMaquina) data_vga = regs[ix];
          else                  regs[ix] = DATA_WRITE;
        end
      end
    end
  end

  // Directed stimulus
  initial begin : stim
    reset = 1'b0; inc = 1'b0; dec = 1'b0; edit_sel = 3'd0;
    regs[0] = 8'h45; regs[1] = 8'h30; regs[2] = 8'h12;
    regs[3] = 8'h07; regs[4] = 8'h09; regs[5] = 8'h17;
    repeat (4) @(negedge clk);
    check8("rst_address", address, 8'h21);
    check8("rst_data_write", DATA_WRITE, 8'h00);
    check8("rst_ind", {7'd0, IndicadorMaquina}, 8'h01);
    check8("rst_busy", {7'd0, busy}, 8'h00);
    check8("rst_seg", seg, 8'h00);
    check8("rst_anio", anio, 8'h00);

    // Poll after reset
    push_reads();
    reset = 1'b1;
    wait_sweep_end("poll0");
    check8("poll_seg", seg, 8'h45);
    check8("poll_min", min, 8'h30);
    check8("poll_hora", hora, 8'h12);
    check8("poll_dia", dia, 8'h07);
    check8("poll_mes", mes, 8'h09);
    check8("poll_anio", anio, 8'h17);

    // Load min=59 and mes=01 through a poll, then increment min with carry
    regs[1] = 8'h59; regs[4] = 8'h01;
    push_reads();
    wait_sweep_end("poll1");
    check8("pre_min", min, 8'h59);
    check8("pre_mes", mes, 8'h01);
    pulse(1'b1, 1'b0, 3'd1);
    push_write(8'h22, 8'h00);
    push_reads();
    wait_txn("after_inc_rd21", 8'h21, 1'b1);
    check8("inc_min_optimistic", min, 8'h00);
    wait_sweep_end("poll2");
    check8("inc_min", min, 8'h00);

    // Decrement wrap on mes while idx 2 is in flight
    push_reads();
    exp_q.insert(3, '{addr: 8'h25, data: 8'h12, rd: 1'b0});
    wait_txn("rd23", 8'h23, 1'b1);
    repeat (20) @(negedge clk);
    pulse(1'b0, 1'b1, 3'd4);
    wait_sweep_end("poll3");
    check8("dec_mes", mes, 8'h12);

    // Conflicting and invalid requests are ignored
    regs[0] = 8'h09;
    @(negedge clk);
    inc = 1'b1; dec = 1'b1; edit_sel = 3'd1;
    @(negedge clk);
    dec = 1'b0; edit_sel = 3'd7;
    @(negedge clk);
    inc = 1'b0; edit_sel = 3'd0;
    push_reads();
    wait_sweep_end("poll4");
    check8("ign_seg", seg, 8'h09);
    check8("ign_min", min, 8'h00);

    // Second edit while one is pending is dropped
    pulse(1'b1, 1'b0, 3'd0);
    repeat (5) @(negedge clk);
    pulse(1'b1, 1'b0, 3'd2);
    push_write(8'h21, 8'h10);
    push_reads();
    wait_sweep_end("poll5");
    check8("drop_seg", seg, 8'h10);
    check8("drop_hora", hora, 8'h12);

    // Reset in the middle of a write
    pulse(1'b1, 1'b0, 3'd5);
    push_write(8'h26, 8'h18);
    wait_txn("wr26", 8'h26, 1'b0);
    repeat (29) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check8("mrst_address", address, 8'h21);
    check8("mrst_data_write", DATA_WRITE, 8'h00);
    check8("mrst_ind", {7'd0, IndicadorMaquina}, 8'h01);
    check8("mrst_busy", {7'd0, busy}, 8'h00);
    check8("mrst_anio", anio, 8'h00);
    push_reads();
    @(negedge clk);
    reset = 1'b1;
    wait_sweep_end("poll6");
    check8("mrst_anio_poll", anio, 8'h17);
    check8("mrst_seg_poll", seg, 8'h10);

    check8("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
